uart_tx_interface: RTL

Return-path framer between the ALU result and the UART transmitter. On a result-valid pulse it captures the signed ALU result, splits it into N_BYTES bytes (LSB first), and feeds them one at a time to the UART TX core through a start/done handshake. It is the counterpart of the RX-side operand collector, closing the PC -> UART RX -> ALU -> UART TX loop.

---
 rtl/uart_tx_interface_pkg.sv | 16 +
 rtl/uart_tx_interface.sv | 131 +++++++++++++
 2 files changed

// File: rtl/uart_tx_interface_pkg.sv
// uart_tx_interface_pkg
// Shared definitions for the UART return path. The framer, the UART TX core
// and the RX-side operand collector all use these.
//   NB_DATA_DEFAULT : default UART byte width
//   tx_state_t      : framer state encoding (IDLE=0, START=1, WAIT=2)
package uart_tx_interface_pkg;

  localparam int NB_DATA_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_interface.sv
// uart_tx_interface
// Return-path framer between the ALU and the UART transmitter. A result-valid
// pulse captures the signed ALU result. The result is then sent LSB byte first
// to the UART TX core, one byte per start/done handshake.
// Ports:
//   i_clock    : clock, rising edge
//   i_reset    : asynchronous active-low reset
//   i_valid    : one-cycle pulse, i_result is valid
//   i_result   : signed ALU result (NB_RESULT bits)
//   o_ready    : an i_valid pulse in this cycle is accepted (combinational)
//   o_tx_start : one-cycle load pulse to the UART TX core
//   o_tx_data  : byte to transmit, held until the next byte is loaded
//   i_tx_done  : one-cycle pulse from the UART TX core, stop bit finished
//   o_busy     : a frame is in progress
//   o_overrun  : sticky flag, an i_valid pulse was dropped
module uart_tx_interface
  import uart_tx_interface_pkg::*;
#(
  parameter int  NB_DATA   = NB_DATA_DEFAULT,
  parameter int  N_BYTES   = 2,
  parameter int  NB_IDX    = 2,
  localparam int NB_RESULT = NB_DATA * N_BYTES
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [NB_RESULT-1:0] i_result,
  output logic                 o_ready,
  output logic                 o_tx_start,
  output logic [NB_DATA-1:0]   o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_overrun
);

  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES - 1);

  tx_state_t              state_r;
  logic [NB_IDX-1:0]      idx_r;
  logic [NB_RESULT-1:0]   shift_r;
  logic [NB_RESULT-1:0]   next_shift_s;
  logic                   tx_start_r;
  logic [NB_DATA-1:0]     tx_data_r;
  logic                   busy_r;
  logic                   overrun_r;
  logic                   ready_s;

  // Acceptance window: idle, or the cycle in which the last byte completes.
  always_comb begin
    ready_s = 1'b0;
    if (state_r == ST_IDLE) begin
      ready_s = 1'b1;
    end else if ((state_r == ST_WAIT) && i_tx_done && (idx_r == LAST_IDX)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  // The next byte is always the low slice after one shift, so no byte mux is needed.
  always_comb begin
    next_shift_s = shift_r >> NB_DATA;
  end

  // Framer FSM with shift register, byte index, registered outputs and sticky overrun.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      shift_r    <= '0;
      tx_start_r <= 1'b0;
      tx_data_r  <= '0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      if (i_valid && !ready_s) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          // A done pulse here is stale, for example after a reset, and is ignored.
          if (i_valid) begin
            shift_r    <= i_result;
            idx_r      <= '0;
            tx_start_r <= 1'b1;
            tx_data_r  <= i_result[NB_DATA-1:0];
            busy_r     <= 1'b1;
            state_r    <= ST_START;
          end
        end
        ST_START: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_tx_done && (idx_r != LAST_IDX)) begin
            shift_r    <= next_shift_s;
            idx_r      <= idx_r + NB_IDX'(1'b1);
            tx_start_r <= 1'b1;
            tx_data_r  <= next_shift_s[NB_DATA-1:0];
            state_r    <= ST_START;
          end else if (i_tx_done) begin
            // The last byte is done. A valid pulse in the same cycle starts the next frame.
            if (i_valid) begin
              shift_r    <= i_result;
              idx_r      <= '0;
              tx_start_r <= 1'b1;
              tx_data_r  <= i_result[NB_DATA-1:0];
              state_r    <= ST_START;
            end else begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready    = ready_s;
  assign o_tx_start = tx_start_r;
  assign o_tx_data  = tx_data_r;
  assign o_busy     = busy_r;
  assign o_overrun  = overrun_r;

endmodule
